// File: rtl/key_debouncer.sv
// key_debouncer: per-key two-flop synchroniser followed by a stability-counter debounce with a one-cycle change pulse.
// Optional `KEY_EXCLUSIVE_EN: a press commits only while every other key is released; the lowest index wins ties.
module key_debouncer #(
  parameter int N_KEYS          = 4,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_WIDTH       = 20
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [N_KEYS-1:0] key_raw,
  output logic [N_KEYS-1:0] key_clean,
  output logic [N_KEYS-1:0] key_changed
);
  localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
  logic [N_KEYS-1:0] sync1, sync2, ready, commit;
  logic [CNT_WIDTH-1:0] cnt [N_KEYS];
  always_comb begin
    ready = '0;
    for (int i = 0; i < N_KEYS; i++) ready[i] = (sync2[i] != key_clean[i]) && (cnt[i] == LAST);
`ifdef KEY_EXCLUSIVE_EN
    // with every key released only presses can be ready, so grant the lowest one
    commit = (&key_clean) ? (ready & (~ready + N_KEYS'(1))) : (ready & sync2);
`else
    commit = ready;
`endif
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1       <= '1;
      sync2       <= '1;
      key_clean   <= '1;
      key_changed <= '0;
      for (int i = 0; i < N_KEYS; i++) cnt[i] <= '0;
    end else begin
      sync1       <= key_raw;
      sync2       <= sync1;
      key_changed <= commit;
      for (int i = 0; i < N_KEYS; i++) begin
        if (sync2[i] == key_clean[i]) cnt[i] <= '0;
        else if (commit[i]) begin
          key_clean[i] <= sync2[i];
          cnt[i]       <= '0;
        end else if (!ready[i]) cnt[i] <= cnt[i] + CNT_WIDTH'(1);
      end
    end
  end
endmodule
